// File: rtl/if_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_fetch_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] is;
        logic [31:0] pc4;
    } fetch_word_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// Two-entry IF/ID holding register: an output slot plus one skid slot
// that catches a word returning while decode is stalled.
module if_skid_buf
    import if_fetch_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    input  logic        i_stall,
    input  logic        i_load,
    input  fetch_word_t i_word,
    output logic        o_valid,
    output logic        o_full,
    output fetch_word_t o_word
);

    logic        r_out_v;
    logic        r_skid_v;
    fetch_word_t r_out;
    fetch_word_t r_skid;
    logic        w_free;

    assign w_free  = !r_out_v || !i_stall;
    assign o_valid = r_out_v;
    assign o_full  = r_skid_v;
    assign o_word  = r_out;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_v  <= 1'b0;
            r_skid_v <= 1'b0;
            r_out    <= '0;
            r_skid   <= '0;
        end else if (i_flush) begin
            r_out_v  <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (w_free) begin
            if (r_skid_v) begin
                r_out    <= r_skid;
                r_out_v  <= 1'b1;
                r_skid_v <= i_load;
                if (i_load) begin
                    r_skid <= i_word;
                end
            end else begin
                r_out_v <= i_load;
                if (i_load) begin
                    r_out <= i_word;
                end
            end
        end else if (i_load && !r_skid_v) begin
            // Output slot frozen by the stall: park the word.
            r_skid   <= i_word;
            r_skid_v <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, issues one outstanding word fetch,
// and feeds the decoder through a two-entry holding buffer.
module if_fetch_stage
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_WORD = DEF_NOP_WORD
) (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic        in_stall,
    input  logic        in_redirect,
    input  logic [31:0] in_redirect_pc,
    input  logic        in_halt,
    input  logic        in_resume,
    output logic        out_imem_req,
    output logic [31:0] out_imem_addr,
    input  logic        in_imem_ready,
    input  logic        in_imem_valid,
    input  logic [31:0] in_imem_rdata,
    output logic [31:0] out_is,
    output logic [31:0] out_pc4,
    output logic        out_valid,
    output logic        out_halted
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_fetch_pc;
    logic         r_kill;
    logic         r_halt_pend;

    logic         w_req;
    logic         w_hs;
    logic         w_rsp;
    logic         w_keep;
    logic         w_flush;
    logic         w_to_skid;
    logic         w_buf_valid;
    logic         w_skid_full;
    logic [31:0]  w_rsp_pc4;
    fetch_word_t  w_in_word;
    fetch_word_t  w_out_word;

    assign w_req     = (r_state == ST_REQ) && !w_skid_full;
    assign w_hs      = w_req && in_imem_ready;
    // A zero-latency memory answers in the same cycle as the handshake.
    assign w_rsp     = ((r_state == ST_WAIT) && in_imem_valid)
                    || (w_hs && in_imem_valid);
    assign w_keep    = w_rsp && !r_kill && !in_redirect && !in_halt;
    assign w_flush   = in_redirect || in_halt;
    assign w_to_skid = w_buf_valid && in_stall;
    assign w_rsp_pc4 = ((r_state == ST_WAIT) ? r_fetch_pc : r_pc)
                     + 32'd4;
    assign w_in_word = {in_imem_rdata, w_rsp_pc4};

    assign out_imem_req  = w_req && in_rst_n;
    assign out_imem_addr = r_pc;
    assign out_is        = w_buf_valid ? w_out_word.is : NOP_WORD;
    assign out_pc4       = w_out_word.pc4;
    assign out_valid     = w_buf_valid;
    assign out_halted    = (r_state == ST_HALTED);

    if_skid_buf u_skid (
        .i_clk   (in_clk),
        .i_rst_n (in_rst_n),
        .i_flush (w_flush),
        .i_stall (in_stall),
        .i_load  (w_keep),
        .i_word  (w_in_word),
        .o_valid (w_buf_valid),
        .o_full  (w_skid_full),
        .o_word  (w_out_word)
    );

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state     <= ST_REQ;
            r_pc        <= word_align(RESET_PC);
            r_fetch_pc  <= '0;
            r_kill      <= 1'b0;
            r_halt_pend <= 1'b0;
        end else begin
            if (in_redirect) begin
                r_pc <= word_align(in_redirect_pc);
            end else if (w_keep) begin
                r_pc <= w_rsp_pc4;
            end
            if (w_hs) begin
                r_fetch_pc <= r_pc;
            end
            unique case (r_state)
                ST_REQ: begin
                    if (w_hs && !in_imem_valid) begin
                        r_state     <= ST_WAIT;
                        r_kill      <= w_flush;
                        r_halt_pend <= in_halt;
                    end else if (in_halt) begin
                        r_state <= ST_HALTED;
                    end else if (w_keep && w_to_skid) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_WAIT: begin
                    if (in_imem_valid) begin
                        r_kill      <= 1'b0;
                        r_halt_pend <= 1'b0;
                        if (in_halt || r_halt_pend) begin
                            r_state <= ST_HALTED;
                        end else if (w_keep && w_to_skid) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_state <= ST_REQ;
                        end
                    end else begin
                        r_kill      <= r_kill || w_flush;
                        r_halt_pend <= r_halt_pend || in_halt;
                    end
                end
                ST_HOLD: begin
                    if (in_halt) begin
                        r_state <= ST_HALTED;
                    end else if (in_redirect || !in_stall) begin
                        r_state <= ST_REQ;
                    end
                end
                ST_HALTED: begin
                    if (in_resume && !in_halt) begin
                        r_state <= ST_REQ;
                    end
                end
                default: r_state <= ST_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: cycle table for streaming/stall, then
// scoreboarded sequences for redirect, wrap, halt and async reset.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        resume;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] o_is;
    logic [31:0] o_pc4;
    logic        o_valid;
    logic        o_halted;

    int          lat;
    int          n_vec;
    int          n_bad;

    int          m_cnt;
    logic        m_vld;
    logic [31:0] m_addr;
    logic [31:0] m_data;

    typedef struct packed {
        logic [31:0] is;
        logic [31:0] pc4;
    } word_t;

    typedef struct {
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] is;
        logic [31:0] pc4;
    } vec_t;

    word_t sb_q[$];
    vec_t  vq[$];
    vec_t  tbl[8];

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .in_clk         (clk),
        .in_rst_n       (rst_n),
        .in_stall       (stall),
        .in_redirect    (redirect),
        .in_redirect_pc (redirect_pc),
        .in_halt        (halt),
        .in_resume      (resume),
        .out_imem_req   (imem_req),
        .out_imem_addr  (imem_addr),
        .in_imem_ready  (imem_ready),
        .in_imem_valid  (imem_valid),
        .in_imem_rdata  (imem_rdata),
        .out_is         (o_is),
        .out_pc4        (o_pc4),
        .out_valid      (o_valid),
        .out_halted     (o_halted)
    );

    // Memory: data = addr + 0x1000; lat 0 is combinational, else delayed.
    assign imem_valid = (lat == 0) ? (imem_req && imem_ready) : m_vld;
    assign imem_rdata = (lat == 0) ? imem_addr + 32'h1000 : m_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_vld  <= 1'b0;
            m_addr <= '0;
            m_data <= '0;
        end else begin
            m_vld <= 1'b0;
            if (imem_req && imem_ready && lat != 0) begin
                m_cnt  <= 3;
                m_addr <= imem_addr;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_vld  <= 1'b1;
                    m_data <= m_addr + 32'h1000;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act,
                        input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic sb_cmp(input string name, input logic [31:0] is_v,
                          input logic [31:0] pc_v);
        word_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: unexpected word %h", name, is_v);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_is"}, is_v, e.is);
            chk({name, "_pc4"}, pc_v, e.pc4);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        halt        = 1'b0;
        resume      = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_req(input string name, output logic [31:0] addr);
        logic seen;
        seen = 1'b0;
        addr = '0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (imem_req && imem_ready) begin
                seen = 1'b1;
                addr = imem_addr;
            end
            cyc();
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: no request within 30 cycles", name);
        end
    endtask

    task automatic expect_word(input string name);
        logic        seen;
        logic [31:0] is_v;
        logic [31:0] pc_v;
        seen = 1'b0;
        is_v = '0;
        pc_v = '0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (o_valid) begin
                seen = 1'b1;
                is_v = o_is;
                pc_v = o_pc4;
            end
            cyc();
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: no valid word within 30 cycles", name);
        end else begin
            sb_cmp(name, is_v, pc_v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic        seen;
        logic        bad;
        vec_t        e;

        n_vec = 0;
        n_bad = 0;

        //            stall req  addr      vld   is          pc4
        tbl[0] = '{1'b0, 1'b1, 32'h0,  1'b0, 32'h0,    32'h0};
        tbl[1] = '{1'b0, 1'b1, 32'h4,  1'b1, 32'h1000, 32'h4};
        tbl[2] = '{1'b1, 1'b1, 32'h8,  1'b1, 32'h1004, 32'h8};
        tbl[3] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h1004, 32'h8};
        tbl[4] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h1004, 32'h8};
        tbl[5] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h1004, 32'h8};
        tbl[6] = '{1'b0, 1'b1, 32'hC,  1'b1, 32'h1008, 32'hC};
        tbl[7] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h100C, 32'h10};

        lat         = 0;
        imem_ready  = 1'b1;
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        halt        = 1'b0;
        resume      = 1'b0;
        #12;
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_valid", o_valid, 1'b0);
        chk("rst_is", o_is, 32'h0);
        chk("rst_pc4", o_pc4, 32'h0);
        chk1("rst_halted", o_halted, 1'b0);
        cyc();
        rst_n = 1'b1;

        // Streaming at one word per cycle, then a 3-cycle stall.
        for (int i = 0; i < 8; i++) begin
            stall = tbl[i].stall;
            vq.push_back(tbl[i]);
            @(negedge clk);
            e = vq.pop_front();
            chk1($sformatf("t%0d_valid", i), o_valid, e.vld);
            chk($sformatf("t%0d_is", i), o_is, e.is);
            chk($sformatf("t%0d_pc4", i), o_pc4, e.pc4);
            chk1($sformatf("t%0d_req", i), imem_req, e.req);
            if (e.req) begin
                chk($sformatf("t%0d_addr", i), imem_addr, e.addr);
            end
            cyc();
        end

        // Redirect while a 3-cycle fetch is outstanding.
        lat = 3;
        do_reset();
        sb_q.push_back('{32'h1100, 32'h104});
        cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        chk1("redir_wait_req", imem_req, 1'b0);
        cyc();
        redirect = 1'b0;
        wait_req("redir_addr", a);
        chk("redir_addr", a, 32'h100);
        expect_word("redir_word");

        // PC wrap at the top of the address space.
        lat        = 0;
        imem_ready = 1'b0;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect   = 1'b0;
        imem_ready = 1'b1;
        sb_q.push_back('{32'h0000_0FFC, 32'h0});
        @(negedge clk);
        chk1("wrap_req", imem_req, 1'b1);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        cyc();
        @(negedge clk);
        chk1("wrap_valid", o_valid, 1'b1);
        sb_cmp("wrap_word", o_is, o_pc4);
        chk("wrap_next_addr", imem_addr, 32'h0);
        cyc();

        // Halt while a fetch is outstanding, then resume.
        lat        = 3;
        imem_ready = 1'b1;
        do_reset();
        cyc();
        halt = 1'b1;
        cyc();
        halt = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = o_halted;
            cyc();
        end
        chk1("halt_entered", seen, 1'b1);
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req || o_valid || !o_halted) bad = 1'b1;
            cyc();
        end
        chk1("halt_idle", bad, 1'b0);
        resume = 1'b1;
        sb_q.push_back('{32'h1000, 32'h4});
        cyc();
        resume = 1'b0;
        wait_req("resume_addr", a);
        chk("resume_addr", a, 32'h0);
        stall = 1'b1;
        expect_word("resume_word");

        // Asynchronous reset with a word held and a fetch in flight.
        @(negedge clk);
        chk1("pre_rst_valid", o_valid, 1'b1);
        chk("pre_rst_pc4", o_pc4, 32'h4);
        chk1("pre_rst_req", imem_req, 1'b0);
        chk1("pre_rst_halted", o_halted, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk1("arst_req", imem_req, 1'b0);
        chk1("arst_valid", o_valid, 1'b0);
        chk("arst_is", o_is, 32'h0);
        chk("arst_pc4", o_pc4, 32'h0);
        chk1("arst_halted", o_halted, 1'b0);
        stall = 1'b0;
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk1("post_rst_req", imem_req, 1'b1);
        chk("post_rst_addr", imem_addr, 32'h0);
        cyc();
        sb_q.push_back('{32'h1000, 32'h4});
        expect_word("post_rst_word");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
